// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory datapath: size codes, FSM states,
// request payload and byte-enable generation.
package mem_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NBYTES = XLEN / 8;
  localparam int unsigned WAIT_W = 4;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  // Request fields latched while an access sits in WAIT
  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sign;
    logic [1:0]        off;
    logic [NBYTES-1:0] be;
    logic [XLEN-1:0]   wdata;
  } mem_req_t;

  // Returns {be[3:0], err}; size 3 is decoded as a word
  function automatic logic [4:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    logic       err;
    be  = 4'b0000;
    err = 1'b0;
    case (size)
      SZ_B: be = 4'b0001 << off;
      SZ_H: begin
        be  = 4'b0011 << off;
        err = off[0];
      end
      default: begin
        be  = 4'b1111;
        err = (off != 2'd0);
      end
    endcase
    return {be, err};
  endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Byte/half lane select from a 32-bit word followed by sign or zero extension.
module dm_lane_ext
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      size,
  input  logic [1:0]      off,
  input  logic            sign,
  output logic [XLEN-1:0] data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];

    data_c = word;
    case (size)
      SZ_B:    data_c = {{24{sign & byte_sel[7]}}, byte_sel};
      SZ_H:    data_c = {{16{sign & half_sel[15]}}, half_sel};
      default: data_c = word;
    endcase
  end

endmodule

// File: rtl/dm_bank.sv
// MEM-stage data memory: byte-addressed loads/stores with lane enables,
// misalign/range detection, wait states and a post-reset clear sweep.
module dm_bank
  import mem_pkg::*;
#(
  parameter  int unsigned DEPTH       = 3072,
  parameter  int unsigned WAIT_CYCLES = 0,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            we,
  input  logic [1:0]      size,
  input  logic            sign,
  input  logic [AW+1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            rvalid,
  output logic [XLEN-1:0] rdata,
  output logic            misalign
);

  logic [XLEN-1:0] mem_array [DEPTH];

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  mem_req_t          req_q, req_d;
  logic [AW-1:0]     widx_q, widx_d;
  logic              busy_q, busy_d;
  logic              rvalid_q, rvalid_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic [XLEN-1:0]   rd_word_q;

  logic [1:0]        off_c;
  logic [AW-1:0]     widx_c;
  logic [NBYTES-1:0] be_c;
  logic              align_err_c;
  logic              range_err_c;
  logic              err_c;
  logic [XLEN-1:0]   wdata_rep_c;
  logic [XLEN-1:0]   ext_c;

  logic              wr_en_c;
  logic [AW-1:0]     wr_idx_c;
  logic [NBYTES-1:0] wr_be_c;
  logic [XLEN-1:0]   wr_data_c;
  logic              rd_en_c;

  // Request decode: lanes, errors and replicated store data
  always_comb begin
    off_c                = addr[1:0];
    widx_c               = addr[AW+1:2];
    {be_c, align_err_c}  = be_gen(size, off_c);
    range_err_c          = {1'b0, widx_c} >= (AW+1)'(DEPTH);
    err_c                = align_err_c | range_err_c;
    case (size)
      SZ_B:    wdata_rep_c = {4{wdata[7:0]}};
      SZ_H:    wdata_rep_c = {2{wdata[15:0]}};
      default: wdata_rep_c = wdata;
    endcase
  end

  dm_lane_ext u_ext (
    .word   (rd_word_q),
    .size   (req_q.size),
    .off    (req_q.off),
    .sign   (req_q.sign),
    .data_c (ext_c)
  );

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    req_d      = req_q;
    widx_d     = widx_q;
    busy_d     = busy_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    wr_en_c    = 1'b0;
    wr_idx_c   = widx_q;
    wr_be_c    = req_q.be;
    wr_data_c  = req_q.wdata;
    rd_en_c    = 1'b0;

    case (state_q)
      S_INIT: begin
        busy_d    = 1'b1;
        wr_en_c   = 1'b1;
        wr_idx_c  = clr_ptr_q;
        wr_be_c   = '1;
        wr_data_c = '0;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          state_d   = S_IDLE;
          busy_d    = 1'b0;
          clr_ptr_d = '0;
        end
      end

      S_IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          if (err_c) begin
            misalign_d = 1'b1;
          end else if (we && (WAIT_CYCLES == 0)) begin
            wr_en_c   = 1'b1;
            wr_idx_c  = widx_c;
            wr_be_c   = be_c;
            wr_data_c = wdata_rep_c;
          end else begin
            req_d   = '{we: we, size: size, sign: sign, off: off_c, be: be_c, wdata: wdata_rep_c};
            widx_d  = widx_c;
            state_d = S_WAIT;
            busy_d  = 1'b1;
            // Loads need one extra cycle for the synchronous read
            wait_cnt_d = we ? WAIT_W'(WAIT_CYCLES - 1) : WAIT_W'(WAIT_CYCLES);
            rd_en_c    = ~we;
          end
        end
      end

      S_WAIT: begin
        busy_d = 1'b1;
        if (wait_cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (req_q.we) begin
            wr_en_c = 1'b1;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = ext_c;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end

      default: state_d = S_INIT;
    endcase

    if (reset) begin
      wr_en_c = 1'b0;
      rd_en_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      clr_ptr_q  <= '0;
      wait_cnt_q <= '0;
      busy_q     <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Datapath holding registers carry no reset
  always_ff @(posedge clk) begin
    req_q  <= req_d;
    widx_q <= widx_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be_c[i]) mem_array[wr_idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en_c) rd_word_q <= mem_array[widx_c];
  end

  assign busy     = busy_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_dm_bank.sv
// Directed bench: dut_a (DEPTH 3072, no wait states) and dut_b (DEPTH 64, 3 wait states).
module tb_dm_bank;
  import mem_pkg::*;

  localparam int unsigned A_DEPTH = 3072;
  localparam int unsigned B_DEPTH = 64;

  logic clk;
  logic a_reset, a_req, a_we, a_sign, a_busy, a_rvalid, a_misalign;
  logic [1:0] a_size;
  logic [13:0] a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic b_reset, b_req, b_we, b_sign, b_busy, b_rvalid, b_misalign;
  logic [1:0] b_size;
  logic [7:0] b_addr;
  logic [31:0] b_wdata, b_rdata;

  int n_checks;
  int n_fail;

  dm_bank #(.DEPTH(A_DEPTH), .WAIT_CYCLES(0)) dut_a (
    .clk(clk), .reset(a_reset), .req(a_req), .we(a_we), .size(a_size), .sign(a_sign),
    .addr(a_addr), .wdata(a_wdata), .busy(a_busy), .rvalid(a_rvalid), .rdata(a_rdata),
    .misalign(a_misalign)
  );

  dm_bank #(.DEPTH(B_DEPTH), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .reset(b_reset), .req(b_req), .we(b_we), .size(b_size), .sign(b_sign),
    .addr(b_addr), .wdata(b_wdata), .busy(b_busy), .rvalid(b_rvalid), .rdata(b_rdata),
    .misalign(b_misalign)
  );

  always #5 clk = ~clk;

  // Waits for idle, presents one request, then watches 8 cycles after the accepting edge
  task automatic issue(input bit b, input bit we, input logic [1:0] sz, input bit sg,
                       input logic [31:0] ad, input logic [31:0] wd,
                       output int rv_k, output int mis_k, output int n_pulse,
                       output logic [31:0] data);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((b ? b_busy : a_busy) && guard < 5000) begin
      guard++;
      @(negedge clk);
    end
    n_checks++;
    if (guard >= 5000) begin
      n_fail++;
      $display("FAIL issue_wait_idle busy=1 after %0d cycles, required 0", guard);
    end
    if (b) begin
      b_req = 1'b1; b_we = we; b_size = sz; b_sign = sg; b_addr = 8'(ad); b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_size = sz; a_sign = sg; a_addr = 14'(ad); a_wdata = wd;
    end
    @(posedge clk);
    rv_k = -1; mis_k = -1; n_pulse = 0; data = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        a_req = 1'b0;
        b_req = 1'b0;
      end
      if (b ? b_rvalid : a_rvalid) begin
        if (rv_k < 0) rv_k = k;
        n_pulse++;
        data = b ? b_rdata : a_rdata;
      end
      if (b ? b_misalign : a_misalign) begin
        if (mis_k < 0) mis_k = k;
        n_pulse++;
      end
    end
  endtask

  task automatic test_reset();
    int ca, cb;
    a_reset = 1'b1; b_reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (a_busy !== 1'b1)    begin n_fail++; $display("FAIL reset_busy got %b want 1", a_busy); end
    if (a_rvalid !== 1'b0)  begin n_fail++; $display("FAIL reset_rvalid got %b want 0", a_rvalid); end
    if (a_rdata !== 32'h0)  begin n_fail++; $display("FAIL reset_rdata got %h want 0", a_rdata); end
    if (a_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got %b want 0", a_misalign); end
    if (b_busy !== 1'b1)    begin n_fail++; $display("FAIL reset_busy_b got %b want 1", b_busy); end
    a_reset = 1'b0; b_reset = 1'b0;
    ca = 0; cb = 0;
    for (int c = 0; c < 5000; c++) begin
      if (a_busy) ca++;
      if (b_busy) cb++;
      if (!a_busy && !b_busy) break;
      @(negedge clk);
    end
    n_checks += 2;
    if (ca != int'(A_DEPTH)) begin n_fail++; $display("FAIL init_cycles_a got %0d want %0d", ca, A_DEPTH); end
    if (cb != int'(B_DEPTH)) begin n_fail++; $display("FAIL init_cycles_b got %0d want %0d", cb, B_DEPTH); end
  endtask

  task automatic test_init_clear();
    int rv, mis, np;
    logic [31:0] d;
    issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, rv, mis, np, d);
    n_checks += 3;
    if (d !== 32'h0) begin n_fail++; $display("FAIL init_word0 got %h want 00000000", d); end
    if (rv != 1)     begin n_fail++; $display("FAIL load_latency got %0d want 1", rv); end
    if (np != 1)     begin n_fail++; $display("FAIL load_pulses got %0d want 1", np); end
    issue(1'b0, 1'b0, SZ_W, 1'b0, (A_DEPTH - 1) * 4, 32'h0, rv, mis, np, d);
    n_checks += 2;
    if (d !== 32'h0) begin n_fail++; $display("FAIL init_top_word got %h want 00000000", d); end
    if (rv != 1)     begin n_fail++; $display("FAIL top_load_rvalid got %0d want 1", rv); end
  endtask

  task automatic test_load_ext();
    int rv, mis, np;
    logic [31:0] d;
    issue(1'b0, 1'b1, SZ_W, 1'b0, 32'h10, 32'h80FF7F01, rv, mis, np, d);
    n_checks++;
    if (np != 0) begin n_fail++; $display("FAIL store_pulses got %0d want 0", np); end
    issue(1'b0, 1'b0, SZ_B, 1'b1, 32'h11, 32'h0, rv, mis, np, d);
    n_checks++;
    if (d !== 32'h0000007F) begin n_fail++; $display("FAIL lb_11 got %h want 0000007f", d); end
    issue(1'b0, 1'b0, SZ_B, 1'b1, 32'h13, 32'h0, rv, mis, np, d);
    n_checks++;
    if (d !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_13 got %h want ffffff80", d); end
    issue(1'b0, 1'b0, SZ_B, 1'b0, 32'h13, 32'h0, rv, mis, np, d);
    n_checks++;
    if (d !== 32'h00000080) begin n_fail++; $display("FAIL lbu_13 got %h want 00000080", d); end
    issue(1'b0, 1'b0, SZ_H, 1'b1, 32'h12, 32'h0, rv, mis, np, d);
    n_checks++;
    if (d !== 32'hFFFF80FF) begin n_fail++; $display("FAIL lh_12 got %h want ffff80ff", d); end
    issue(1'b0, 1'b0, SZ_H, 1'b0, 32'h12, 32'h0, rv, mis, np, d);
    n_checks++;
    if (d !== 32'h000080FF) begin n_fail++; $display("FAIL lhu_12 got %h want 000080ff", d); end
    issue(1'b0, 1'b0, 2'd3, 1'b1, 32'h10, 32'h0, rv, mis, np, d);
    n_checks++;
    if (d !== 32'h80FF7F01) begin n_fail++; $display("FAIL size3_word got %h want 80ff7f01", d); end
  endtask

  task automatic test_partial_store();
    int rv, mis, np;
    logic [31:0] d;
    issue(1'b0, 1'b1, SZ_W, 1'b0, 32'h20, 32'h11223344, rv, mis, np, d);
    issue(1'b0, 1'b1, SZ_B, 1'b0, 32'h22, 32'h000000AB, rv, mis, np, d);
    issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, rv, mis, np, d);
    n_checks++;
    if (d !== 32'h11AB3344) begin n_fail++; $display("FAIL sb_22 got %h want 11ab3344", d); end
    issue(1'b0, 1'b1, SZ_H, 1'b0, 32'h20, 32'h0000BEEF, rv, mis, np, d);
    issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, rv, mis, np, d);
    n_checks++;
    if (d !== 32'h11ABBEEF) begin n_fail++; $display("FAIL sh_20 got %h want 11abbeef", d); end
  endtask

  task automatic test_misalign();
    int rv, mis, np;
    logic [31:0] d;
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    logic        wes   [3];
    addrs[0] = 32'h21;         sizes[0] = SZ_W; wes[0] = 1'b0;
    addrs[1] = 32'h23;         sizes[1] = SZ_H; wes[1] = 1'b1;
    addrs[2] = A_DEPTH * 4;    sizes[2] = SZ_W; wes[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, wes[i], sizes[i], 1'b0, addrs[i], 32'hDEADDEAD, rv, mis, np, d);
      n_checks += 3;
      if (mis != 0) begin n_fail++; $display("FAIL misalign_cycle_%0d got %0d want 0", i, mis); end
      if (rv != -1) begin n_fail++; $display("FAIL misalign_rvalid_%0d got %0d want -1", i, rv); end
      if (np != 1)  begin n_fail++; $display("FAIL misalign_pulses_%0d got %0d want 1", i, np); end
    end
    issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, rv, mis, np, d);
    n_checks++;
    if (d !== 32'h11ABBEEF) begin n_fail++; $display("FAIL misalign_unchanged got %h want 11abbeef", d); end
    issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, rv, mis, np, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL range_no_wrap got %h want 00000000", d); end
  endtask

  task automatic test_back_to_back();
    int rv, mis, np;
    logic [31:0] d;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_size = SZ_W; a_addr = 14'h30; a_wdata = 32'hA5A5_0001;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy1 got %b want 0", a_busy); end
    a_addr = 14'h34; a_wdata = 32'h5A5A_0002;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy2 got %b want 0", a_busy); end
    a_we = 1'b0;
    @(posedge clk); @(negedge clk);
    a_req = 1'b0;
    n_checks++;
    if (a_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_load_busy got %b want 1", a_busy); end
    @(negedge clk);
    n_checks += 2;
    if (a_rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid got %b want 1", a_rvalid); end
    if (a_rdata !== 32'h5A5A_0002) begin n_fail++; $display("FAIL b2b_rdata got %h want 5a5a0002", a_rdata); end
    issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h30, 32'h0, rv, mis, np, d);
    n_checks++;
    if (d !== 32'hA5A5_0001) begin n_fail++; $display("FAIL b2b_first got %h want a5a50001", d); end
  endtask

  task automatic test_wait_states();
    int rv, mis, np, nb, rv1, rv2, extra, guard;
    logic [31:0] d, d1, d2;
    issue(1'b1, 1'b1, SZ_W, 1'b0, 32'h10, 32'h0BAD_F00D, rv, mis, np, d);
    issue(1'b1, 1'b1, SZ_W, 1'b0, 32'h14, 32'hC0DE_1234, rv, mis, np, d);
    guard = 0;
    @(negedge clk);
    while (b_busy && guard < 100) begin guard++; @(negedge clk); end
    b_req = 1'b1; b_we = 1'b0; b_size = SZ_W; b_sign = 1'b0; b_addr = 8'h10;
    @(posedge clk);
    nb = 0; rv1 = -1; rv2 = -1; extra = 0; d1 = '0; d2 = '0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k == 0) b_addr = 8'h14;
      if (k == 5) b_req = 1'b0;
      if (k <= 4 && b_busy) nb++;
      if (b_rvalid) begin
        if (rv1 < 0) begin rv1 = k; d1 = b_rdata; end
        else if (rv2 < 0) begin rv2 = k; d2 = b_rdata; end
        else extra++;
      end
    end
    n_checks += 6;
    if (nb != 4)                begin n_fail++; $display("FAIL wait_busy_cycles got %0d want 4", nb); end
    if (rv1 != 4)               begin n_fail++; $display("FAIL wait_rvalid1 got %0d want 4", rv1); end
    if (d1 !== 32'h0BAD_F00D)   begin n_fail++; $display("FAIL wait_rdata1 got %h want 0badf00d", d1); end
    if (rv2 != 9)               begin n_fail++; $display("FAIL held_rvalid2 got %0d want 9", rv2); end
    if (d2 !== 32'hC0DE_1234)   begin n_fail++; $display("FAIL held_rdata2 got %h want c0de1234", d2); end
    if (extra != 0)             begin n_fail++; $display("FAIL held_extra_rvalid got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid_wait();
    int rv, mis, np, cb, guard;
    logic [31:0] d;
    guard = 0;
    @(negedge clk);
    while (b_busy && guard < 100) begin guard++; @(negedge clk); end
    b_req = 1'b1; b_we = 1'b1; b_size = SZ_W; b_addr = 8'h40; b_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    b_req = 1'b0;
    @(negedge clk);
    b_reset = 1'b1;
    @(negedge clk);
    b_reset = 1'b0;
    cb = 0;
    for (int c = 0; c < 200; c++) begin
      if (!b_busy) break;
      cb++;
      @(negedge clk);
    end
    n_checks++;
    if (cb != int'(B_DEPTH)) begin n_fail++; $display("FAIL reinit_cycles got %0d want %0d", cb, B_DEPTH); end
    issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h40, 32'h0, rv, mis, np, d);
    n_checks += 2;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_drop_store got %h want 00000000", d); end
    if (rv != 4)     begin n_fail++; $display("FAIL reset_load_latency got %0d want 4", rv); end
  endtask

  initial begin
    clk = 1'b0;
    n_checks = 0; n_fail = 0;
    a_reset = 1'b1; a_req = 1'b0; a_we = 1'b0; a_size = SZ_W; a_sign = 1'b0; a_addr = '0; a_wdata = '0;
    b_reset = 1'b1; b_req = 1'b0; b_we = 1'b0; b_size = SZ_W; b_sign = 1'b0; b_addr = '0; b_wdata = '0;
    test_reset();
    test_init_clear();
    test_load_ext();
    test_partial_store();
    test_misalign();
    test_back_to_back();
    test_wait_states();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_bank.md
# dm_bank

Parametrised data memory for the MEM stage of the pipelined CPU. It takes byte addresses with an access size and signedness, generates byte-lane enables internally, and flags misaligned accesses. It returns sign- or zero-extended load data with a configurable wait-state count. After reset it clears the whole array and stays busy until the clear is done, so the pipeline stalls on `busy`.

## Interface
- `DEPTH`, 3072: number of 32-bit words; `AW = $clog2(DEPTH)` word-address bits.
- `WAIT_CYCLES`, 0: extra stall cycles per access (0..15).
- `clk`  in  1  single clock; everything changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `req`  in  1  access request; sampled only when `busy`=0.
- `we`  in  1  1 = store, 0 = load.
- `size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `sign`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `addr`  in  AW+2  byte address.
- `wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `busy`  out  1  high during init clear and while an access is in progress.
- `rvalid`  out  1  one-cycle pulse when `rdata` is valid for a load.
- `rdata`  out  32  extended load data; holds its value until the next `rvalid`.
- `misalign`  out  1  one-cycle pulse: the request was dropped, nothing was written or read.

## Operation
- Byte enables (`off = addr[1:0]`):
  - byte → `4'b0001 << off`.
  - half → `4'b0011 << off`; misaligned when `off[0]`=1.
  - word → `4'b1111`; misaligned when `off`≠0.
- Store: the write lane is `wdata` replicated (byte ×4, half ×2). Only enabled lanes are written, at word `addr[AW+1:2]`.
- Load: select the byte or half at `off`, then sign- or zero-extend to 32 bits. Word loads ignore `sign`.
- An out-of-range word index (≥ `DEPTH`) behaves like a misalign: error pulse, no access.
- FSM states:
  - INIT: write 0 to word `clr_ptr`, increment, one word per cycle. `busy`=1. Go to IDLE after writing word `DEPTH-1`.
  - IDLE: `busy`=0.
    - `req` & error → pulse `misalign` next cycle, stay in IDLE.
    - `req` & store with `WAIT_CYCLES`=0 → write at this edge, stay in IDLE.
    - `req` otherwise → latch the request, go to WAIT.
  - WAIT: `busy`=1; the wait counter counts down from `WAIT_CYCLES`. At 0 → perform the access and go to IDLE.
    - Loads use a synchronous array read, registered into `rdata` with an `rvalid` pulse.
- Loads always take at least one cycle (synchronous read), so a zero-wait load spends exactly one cycle in WAIT.
- `reset` in any state forces INIT with `clr_ptr`=0. Any latched request is discarded and no write is performed.
- `req` while `busy`=1 is ignored; the pipeline must hold it.

## Timing
- Reset values: `busy`=1, `rvalid`=0, `rdata`=0, `misalign`=0.
- Init takes `DEPTH` cycles after `reset` deasserts. `busy` falls on the edge after the last clear write.
- Load request accepted at edge N → `rvalid`/`rdata` at edge N+1+`WAIT_CYCLES`. `busy` is high for cycles N..N+`WAIT_CYCLES`.
- Store with `WAIT_CYCLES`=0: written at the accepting edge; `busy` stays 0, so stores can issue back-to-back.
- Store with `WAIT_CYCLES`>0: written at edge N+`WAIT_CYCLES`.
- Load of a word stored at edge N, issued at edge N+1 or later: returns the new data. Stores are never overlapped with a load because there is a single port.
- `misalign` is asserted in the cycle after the accepting edge and never coincides with `rvalid`.

## Structure
- Shared package `mem_pkg`: size encodings (`SZ_B`, `SZ_H`, `SZ_W`), FSM state enum (`S_INIT`, `S_IDLE`, `S_WAIT`), and a function `be_gen(size, off) → {be[3:0], err}`.
- One sub-module, `dm_lane_ext`: combinational byte/half select plus sign/zero extension, reused by the cache fill path.
- The array is a plain `reg [31:0]` with one write port and one synchronous read port, so it can be inferred as block RAM.

## Test plan
- Reset → `busy` high for exactly `DEPTH` cycles; afterwards a word load at 0x0 and at the top word both return 0x00000000.
- With `WAIT_CYCLES`=0: sw 0x80FF7F01 @0x10, then lb @0x11 → 0x0000007F, lb @0x13 → 0xFFFFFF80, lbu @0x13 → 0x00000080, lh @0x12 → 0xFFFF80FF, lhu @0x12 → 0x000080FF.
- sb 0xAB @0x22 over word 0x11223344 → word load @0x20 returns 0x11AB3344; sh 0xBEEF @0x20 → 0x11ABBEEF.
- lw @0x21, sh @0x23, and word index `DEPTH` → `misalign` pulses once each, memory unchanged, `rvalid` never asserted.
- `WAIT_CYCLES`=3: load accepted at edge N → `busy` high 4 cycles, `rvalid` at N+4; a `req` held during `busy` is served only once `busy` is low again.
- `reset` asserted mid-WAIT on a store → store not performed, init re-runs, the target word reads 0.
